// File: rtl/ldst_pkg.sv
// Shared definitions for the block-organised load/store unit: access size
// encodings, FSM states, functional-unit code and byte-lane helpers.
package ldst_pkg;

  localparam logic [1:0] SIZE_BYTE  = 2'd0;
  localparam logic [1:0] SIZE_HALF  = 2'd1;
  localparam logic [1:0] SIZE_WORD  = 2'd2;
  localparam logic [1:0] SIZE_DWORD = 2'd3;

  // Functional-unit code used by dispatch to route operations here.
  localparam int LdStUnitCode = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC1,
    ST_ACC2,
    ST_RESP
  } state_t;

  // Number of bytes touched by an access of the given size.
  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

  // Bits of padding left of a right-justified value of the given size in 64 bits.
  function automatic logic [6:0] pad_bits(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 7'd56;
      SIZE_HALF: return 7'd48;
      SIZE_WORD: return 7'd32;
      default:   return 7'd0;
    endcase
  endfunction

  // Byte-lane mask, MSB = first (lowest-address) byte of the access.
  function automatic logic [7:0] lane_mask(input logic [1:0] size);
    return 8'hFF << (4'd8 - size_bytes(size));
  endfunction

endpackage

// File: rtl/ldst_align_extract.sv
// Combinational load alignment: picks the accessed bytes out of two
// consecutive big-endian memory blocks, right-justifies and extends them.
module ldst_align_extract
  import ldst_pkg::*;
#(
  parameter int BLOCK_BYTES = 16,
  parameter int OFF_W       = $clog2(BLOCK_BYTES)
) (
  input  logic [BLOCK_BYTES*8-1:0] block0,
  input  logic [BLOCK_BYTES*8-1:0] block1,
  input  logic [OFF_W-1:0]         offset,
  input  logic [1:0]               size,
  input  logic                     sign_extend,
  output logic [63:0]              value
);

  localparam int WIN_W = 2 * BLOCK_BYTES * 8;

  logic [WIN_W-1:0] shifted;
  logic [63:0]      top;
  logic [63:0]      raw;

  // Zero- or sign-extend a right-justified access; doublewords pass through.
  function automatic logic [63:0] extend(input logic [63:0] r, input logic [1:0] sz,
                                         input logic sext);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] w;
    logic signed [63:0] s;
    b = r[7:0];
    h = r[15:0];
    w = r[31:0];
    case (sz)
      SIZE_BYTE: begin s = b; return sext ? s : {56'd0, r[7:0]};  end
      SIZE_HALF: begin s = h; return sext ? s : {48'd0, r[15:0]}; end
      SIZE_WORD: begin s = w; return sext ? s : {32'd0, r[31:0]}; end
      default:   return r;
    endcase
  endfunction

  // Slide the accessed bytes to the top of the window, then right-justify.
  always_comb begin
    shifted = {block0, block1} << {offset, 3'b000};
    top     = shifted[WIN_W-1 -: 64];
    raw     = top >> pad_bits(size);
    value   = extend(raw, size, sign_extend);
  end

endmodule

// File: rtl/ldst_block_unit.sv
// Load/store functional unit over a block-organised, big-endian byte memory.
// One operation in flight; stores commit in a single edge, loads that cross a
// block boundary take an extra fetch of the following block.
module ldst_block_unit
  import ldst_pkg::*;
#(
  parameter int BLOCK_BYTES    = 16,
  parameter int NUM_BLOCKS     = 128,
  parameter int ADDR_WIDTH     = 64,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic                      opValid_i,
  output logic                      ready_o,
  input  logic                      isStore_i,
  input  logic [1:0]                size_i,
  input  logic                      signExtend_i,
  input  logic                      update_i,
  input  logic [ADDR_WIDTH-1:0]     base_i,
  input  logic [ADDR_WIDTH-1:0]     offset_i,
  input  logic [63:0]               storeData_i,
  input  logic [REG_ADDR_WIDTH-1:0] rtAddress_i,
  input  logic [REG_ADDR_WIDTH-1:0] raAddress_i,
  output logic                      outputEnable_o,
  output logic                      error_o,
  output logic                      reg1WritebackEnable_o,
  output logic                      reg2WritebackEnable_o,
  output logic [REG_ADDR_WIDTH-1:0] reg1WritebackAddress_o,
  output logic [REG_ADDR_WIDTH-1:0] reg2WritebackAddress_o,
  output logic [63:0]               reg1WritebackVal_o,
  output logic [63:0]               reg2WritebackVal_o
);

  localparam int OFF_W     = $clog2(BLOCK_BYTES);
  localparam int BLK_W     = $clog2(NUM_BLOCKS);
  localparam int BLK_BITS  = BLOCK_BYTES * 8;
  localparam int WIN_W     = 2 * BLK_BITS;
  localparam int MEM_BYTES = BLOCK_BYTES * NUM_BLOCKS;

  state_t state;

  logic [BLK_BITS-1:0] mem [NUM_BLOCKS];

  logic [ADDR_WIDTH-1:0]     ea_q;
  logic                      is_store_q;
  logic [1:0]                size_q;
  logic                      sext_q;
  logic                      update_q;
  logic [63:0]               store_data_q;
  logic [REG_ADDR_WIDTH-1:0] rt_q;
  logic [REG_ADDR_WIDTH-1:0] ra_q;
  logic [BLK_BITS-1:0]       blk0_q;

  logic [OFF_W-1:0]   off;
  logic [BLK_W-1:0]   blk_idx;
  logic [BLK_W-1:0]   blk_nxt;
  logic               crosses;
  logic               fault;
  logic               load_cross;
  logic               complete;
  logic               do_store;
  logic [BLK_BITS-1:0] ext_block0;
  logic [63:0]        load_val;
  logic [WIN_W-1:0]   lane_win_bytes;
  logic [2*BLOCK_BYTES-1:0] lane_win;
  logic [WIN_W-1:0]   data_win;
  logic [WIN_W-1:0]   new_win;
  logic [63:0]        sd_left;

  // Address decomposition, fault detection and completion decode for the op in flight.
  always_comb begin
    off        = ea_q[OFF_W-1:0];
    blk_idx    = ea_q[OFF_W +: BLK_W];
    blk_nxt    = blk_idx + 1'b1;
    crosses    = ({1'b0, off} + (OFF_W+1)'(size_bytes(size_q))) > (OFF_W+1)'(BLOCK_BYTES);
    fault      = (({1'b0, ea_q} + {{(ADDR_WIDTH-3){1'b0}}, size_bytes(size_q)})
                   > (ADDR_WIDTH+1)'(MEM_BYTES))
               || (update_q && (ra_q == '0))
               || (update_q && !is_store_q && (ra_q == rt_q));
    load_cross = !fault && !is_store_q && crosses;
    complete   = ((state == ST_ACC1) && !load_cross) || (state == ST_ACC2);
    do_store   = (state == ST_ACC1) && is_store_q && !fault;
    ext_block0 = (state == ST_ACC2) ? blk0_q : mem[blk_idx];
  end

  ldst_align_extract #(
    .BLOCK_BYTES(BLOCK_BYTES)
  ) u_extract (
    .block0     (ext_block0),
    .block1     (mem[blk_nxt]),
    .offset     (off),
    .size       (size_q),
    .sign_extend(sext_q),
    .value      (load_val)
  );

  // Byte-masked merge of the store data into the two-block window at EA.
  always_comb begin
    sd_left  = store_data_q << pad_bits(size_q);
    lane_win = {lane_mask(size_q), {(2*BLOCK_BYTES-8){1'b0}}} >> off;
    data_win = {sd_left, {(WIN_W-64){1'b0}}} >> {off, 3'b000};
    lane_win_bytes = '0;
    for (int j = 0; j < 2*BLOCK_BYTES; j++) begin
      lane_win_bytes[j*8 +: 8] = {8{lane_win[j]}};
    end
    new_win = ({mem[blk_idx], mem[blk_nxt]} & ~lane_win_bytes) | (data_win & lane_win_bytes);
  end

  // Memory commit: one store edge updates one or both touched blocks.
  always_ff @(posedge clock_i) begin
    if (do_store) begin
      mem[blk_idx] <= new_win[WIN_W-1 -: BLK_BITS];
      if (crosses) begin
        mem[blk_nxt] <= new_win[BLK_BITS-1:0];
      end
    end
  end

  // Operand capture on accept and first-block capture for crossing loads.
  always_ff @(posedge clock_i) begin
    if ((state == ST_IDLE) && opValid_i) begin
      ea_q         <= base_i + offset_i;
      is_store_q   <= isStore_i;
      size_q       <= size_i;
      sext_q       <= signExtend_i && (size_i != SIZE_DWORD);
      update_q     <= update_i;
      store_data_q <= storeData_i;
      rt_q         <= rtAddress_i;
      ra_q         <= raAddress_i;
    end
    if (state == ST_ACC1) begin
      blk0_q <= mem[blk_idx];
    end
  end

  // Sequencing FSM with registered one-cycle completion outputs.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state                  <= ST_IDLE;
      ready_o                <= 1'b1;
      outputEnable_o         <= 1'b0;
      error_o                <= 1'b0;
      reg1WritebackEnable_o  <= 1'b0;
      reg2WritebackEnable_o  <= 1'b0;
      reg1WritebackAddress_o <= '0;
      reg2WritebackAddress_o <= '0;
      reg1WritebackVal_o     <= '0;
      reg2WritebackVal_o     <= '0;
    end else begin
      outputEnable_o         <= 1'b0;
      error_o                <= 1'b0;
      reg1WritebackEnable_o  <= 1'b0;
      reg2WritebackEnable_o  <= 1'b0;
      reg1WritebackAddress_o <= '0;
      reg2WritebackAddress_o <= '0;
      reg1WritebackVal_o     <= '0;
      reg2WritebackVal_o     <= '0;
      case (state)
        ST_IDLE: begin
          if (opValid_i) begin
            state   <= ST_ACC1;
            ready_o <= 1'b0;
          end
        end
        ST_ACC1: state <= load_cross ? ST_ACC2 : ST_RESP;
        ST_ACC2: state <= ST_RESP;
        default: begin
          state   <= ST_IDLE;
          ready_o <= 1'b1;
        end
      endcase
      if (complete) begin
        outputEnable_o <= 1'b1;
        error_o        <= fault;
        if (!fault && !is_store_q) begin
          reg1WritebackEnable_o  <= 1'b1;
          reg1WritebackAddress_o <= rt_q;
          reg1WritebackVal_o     <= load_val;
        end
        if (!fault && update_q) begin
          reg2WritebackEnable_o  <= 1'b1;
          reg2WritebackAddress_o <= ra_q;
          reg2WritebackVal_o     <= 64'(ea_q);
        end
      end
    end
  end

endmodule

// File: tb/tb_ldst_block_unit.sv
// Randomised scoreboard bench for ldst_block_unit against a byte-array model.
module tb_ldst_block_unit;

  localparam int PERIOD = 10;
  localparam int MEMB   = 2048;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        opValid_i;
  logic        ready_o;
  logic        isStore_i;
  logic [1:0]  size_i;
  logic        signExtend_i;
  logic        update_i;
  logic [63:0] base_i;
  logic [63:0] offset_i;
  logic [63:0] storeData_i;
  logic [4:0]  rtAddress_i;
  logic [4:0]  raAddress_i;
  logic        outputEnable_o;
  logic        error_o;
  logic        reg1WritebackEnable_o;
  logic        reg2WritebackEnable_o;
  logic [4:0]  reg1WritebackAddress_o;
  logic [4:0]  reg2WritebackAddress_o;
  logic [63:0] reg1WritebackVal_o;
  logic [63:0] reg2WritebackVal_o;

  always #(PERIOD/2) clk = ~clk;

  ldst_block_unit #(
    .BLOCK_BYTES(16),
    .NUM_BLOCKS(128),
    .ADDR_WIDTH(64),
    .REG_ADDR_WIDTH(5)
  ) dut (
    .clock_i               (clk),
    .reset_i               (reset_i),
    .opValid_i             (opValid_i),
    .ready_o               (ready_o),
    .isStore_i             (isStore_i),
    .size_i                (size_i),
    .signExtend_i          (signExtend_i),
    .update_i              (update_i),
    .base_i                (base_i),
    .offset_i              (offset_i),
    .storeData_i           (storeData_i),
    .rtAddress_i           (rtAddress_i),
    .raAddress_i           (raAddress_i),
    .outputEnable_o        (outputEnable_o),
    .error_o               (error_o),
    .reg1WritebackEnable_o (reg1WritebackEnable_o),
    .reg2WritebackEnable_o (reg2WritebackEnable_o),
    .reg1WritebackAddress_o(reg1WritebackAddress_o),
    .reg2WritebackAddress_o(reg2WritebackAddress_o),
    .reg1WritebackVal_o    (reg1WritebackVal_o),
    .reg2WritebackVal_o    (reg2WritebackVal_o)
  );

  typedef struct {
    logic        err;
    logic        w1e;
    logic [4:0]  w1a;
    logic [63:0] w1v;
    logic        w2e;
    logic [4:0]  w2a;
    logic [63:0] w2v;
    int          lat;
    time         t0;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  logic [7:0]  ref_mem [MEMB];
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Reference behaviour: byte-addressed big-endian memory, plain arithmetic.
  task automatic model(input bit st, input logic [1:0] sz, input bit sx, input bit up,
                       input logic [63:0] ea, input logic [63:0] sd,
                       input logic [4:0] rt, input logic [4:0] ra, output exp_t e);
    int          n;
    int          base_idx;
    logic [64:0] endp;
    logic [63:0] v;
    n    = 1 << sz;
    endp = {1'b0, ea} + 65'(n);
    e.err = (endp > 65'(MEMB)) || (up && ra == 5'd0) || (up && !st && ra == rt);
    e.w1e = 1'b0; e.w1a = '0; e.w1v = '0;
    e.w2e = 1'b0; e.w2a = '0; e.w2v = '0;
    e.lat = 2;
    e.t0  = 0;
    if (!e.err) begin
      base_idx = int'(ea[10:0]);
      if (st) begin
        for (int k = 0; k < n; k++) ref_mem[base_idx + k] = 8'(sd >> (8 * (n - 1 - k)));
      end else begin
        v = '0;
        for (int k = 0; k < n; k++) v = (v << 8) | 64'(ref_mem[base_idx + k]);
        if (sx && sz != 2'd3 && v[8*n-1]) v = v | (~64'd0 << (8 * n));
        e.w1e = 1'b1; e.w1a = rt; e.w1v = v;
        if ((base_idx % 16) + n > 16) e.lat = 3;
      end
      if (up) begin
        e.w2e = 1'b1; e.w2a = ra; e.w2v = ea;
      end
    end
  endtask

  task automatic scramble();
    isStore_i    = 1'($urandom);
    size_i       = 2'($urandom);
    signExtend_i = 1'($urandom);
    update_i     = 1'($urandom);
    base_i       = {$urandom, $urandom};
    offset_i     = {$urandom, $urandom};
    storeData_i  = {$urandom, $urandom};
    rtAddress_i  = 5'($urandom);
    raAddress_i  = 5'($urandom);
  endtask

  // Offer one op, wait for acceptance, record the expected completion.
  task automatic issue(input bit st, input logic [1:0] sz, input bit sx, input bit up,
                       input logic [63:0] base, input logic [63:0] ofs, input logic [63:0] sd,
                       input logic [4:0] rt, input logic [4:0] ra, input bit expect_done);
    exp_t e;
    int   guard;
    @(negedge clk);
    isStore_i = st; size_i = sz; signExtend_i = sx; update_i = up;
    base_i = base; offset_i = ofs; storeData_i = sd;
    rtAddress_i = rt; raAddress_i = ra;
    opValid_i = 1'b1;
    guard = 0;
    while (!ready_o && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!ready_o) begin
      total++; bad++;
      $display("FAIL accept_timeout ready=%b required=1", ready_o);
      opValid_i = 1'b0;
      return;
    end
    model(st, sz, sx, up, base + ofs, sd, rt, ra, e);
    e.t0 = $time;
    if (expect_done) sbq.push_back(e);
    @(negedge clk);
    opValid_i = 1'b0;
    scramble();
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sbq.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_pending", 64'(sbq.size()), 64'd0);
  endtask

  // Monitor: compare every completion against the oldest expectation.
  always @(negedge clk) begin
    if (outputEnable_o) begin
      if (sbq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_completion oe=%b required=0", outputEnable_o);
      end else begin
        mon_e = sbq.pop_front();
        chk("latency", 64'(($time - mon_e.t0) / PERIOD), 64'(mon_e.lat));
        chk("error", 64'(error_o), 64'(mon_e.err));
        chk("wb1_en", 64'(reg1WritebackEnable_o), 64'(mon_e.w1e));
        chk("wb2_en", 64'(reg2WritebackEnable_o), 64'(mon_e.w2e));
        if (mon_e.w1e) begin
          chk("wb1_addr", 64'(reg1WritebackAddress_o), 64'(mon_e.w1a));
          chk("wb1_val", reg1WritebackVal_o, mon_e.w1v);
        end
        if (mon_e.w2e) begin
          chk("wb2_addr", 64'(reg2WritebackAddress_o), 64'(mon_e.w2a));
          chk("wb2_val", reg2WritebackVal_o, mon_e.w2v);
        end
      end
    end else begin
      chk("idle_quiet", {61'd0, error_o, reg1WritebackEnable_o, reg2WritebackEnable_o}, 64'd0);
    end
  end

  initial begin
    logic [63:0] ea;
    reset_i   = 1'b1;
    opValid_i = 1'b0;
    scramble();
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(ready_o), 64'd1);
    chk("rst_oe", 64'(outputEnable_o), 64'd0);
    chk("rst_err", 64'(error_o), 64'd0);
    chk("rst_wb1_en", 64'(reg1WritebackEnable_o), 64'd0);
    chk("rst_wb2_en", 64'(reg2WritebackEnable_o), 64'd0);
    chk("rst_wb1_val", reg1WritebackVal_o, 64'd0);
    chk("rst_wb2_val", reg2WritebackVal_o, 64'd0);
    chk("rst_wb1_addr", 64'(reg1WritebackAddress_o), 64'd0);
    reset_i = 1'b0;

    // Fill memory so every later load has a known model value.
    for (int i = 0; i < MEMB / 8; i++) begin
      issue(1, 2'd3, 0, 0, 64'(i * 8), 64'd0, {$urandom, $urandom}, 5'd0, 5'd0, 1);
    end

    // Directed cases.
    issue(1, 2'd3, 0, 0, 64'h20, 64'h0, 64'h0123456789ABCDEF, 5'd0, 5'd0, 1);
    issue(0, 2'd0, 0, 0, 64'h20, 64'h0, 64'h0, 5'd5, 5'd0, 1);
    issue(1, 2'd1, 1, 0, 64'h30, 64'h10, 64'hFFFF_0000_0000_8001, 5'd0, 5'd0, 1);
    issue(0, 2'd1, 1, 0, 64'h40, 64'h0, 64'h0, 5'd6, 5'd0, 1);
    issue(0, 2'd1, 0, 0, 64'h40, 64'h0, 64'h0, 5'd7, 5'd0, 1);
    issue(1, 2'd3, 0, 0, 64'h1C, 64'h0, 64'h1122334455667788, 5'd0, 5'd0, 1);
    issue(0, 2'd3, 0, 0, 64'h1C, 64'h0, 64'h0, 5'd8, 5'd0, 1);
    issue(0, 2'd3, 0, 0, 64'h10, 64'h0, 64'h0, 5'd8, 5'd0, 1);
    issue(0, 2'd2, 0, 0, 64'h18, 64'h0, 64'h0, 5'd8, 5'd0, 1);
    issue(0, 2'd3, 0, 0, 64'h24, 64'h0, 64'h0, 5'd8, 5'd0, 1);
    issue(0, 2'd2, 0, 0, 64'h2C, 64'h0, 64'h0, 5'd8, 5'd0, 1);
    issue(0, 2'd2, 0, 1, 64'h100, 64'h8, 64'h0, 5'd4, 5'd3, 1);
    issue(0, 2'd2, 0, 0, 64'h7FE, 64'h0, 64'h0, 5'd4, 5'd0, 1);
    issue(0, 2'd2, 0, 0, 64'h7FC, 64'h0, 64'h0, 5'd4, 5'd0, 1);
    issue(0, 2'd2, 0, 1, 64'h100, 64'h0, 64'h0, 5'd4, 5'd0, 1);
    issue(1, 2'd2, 0, 1, 64'h100, 64'h0, 64'hDEADBEEF, 5'd4, 5'd0, 1);
    issue(0, 2'd3, 0, 1, 64'h200, 64'h0, 64'h0, 5'd9, 5'd9, 1);
    issue(0, 2'd2, 0, 0, 64'hFFFF_FFFF_FFFF_FFF0, 64'hE, 64'h0, 5'd4, 5'd0, 1);
    issue(1, 2'd0, 0, 0, 64'h7FF, 64'h0, 64'hA5, 5'd0, 5'd0, 1);
    issue(1, 2'd1, 0, 0, 64'h7FF, 64'h0, 64'hA5A5, 5'd0, 5'd0, 1);
    issue(1, 2'd2, 0, 1, 64'h3F0, 64'hE, 64'hCAFEF00D, 5'd0, 5'd7, 1);
    issue(0, 2'd2, 1, 0, 64'h3FE, 64'h0, 64'h0, 5'd2, 5'd0, 1);
    issue(0, 2'd0, 1, 0, 64'h7FF, 64'h0, 64'h0, 5'd2, 5'd0, 1);

    // Randomised traffic.
    for (int i = 0; i < 300; i++) begin
      ea = 64'($urandom_range(0, MEMB + 8));
      if ($urandom_range(0, 19) == 0) ea = {32'hFFFF_FFFF, $urandom};
      begin
        logic [63:0] b;
        b = {$urandom, $urandom};
        issue(1'($urandom), 2'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
              b, ea - b, {$urandom, $urandom},
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1);
      end
    end
    drain();

    // Reset during the second fetch of a crossing load.
    issue(0, 2'd3, 0, 0, 64'h1C, 64'h0, 64'h0, 5'd9, 5'd1, 0);
    @(negedge clk);
    reset_i = 1'b1;
    #1;
    chk("abort_ready", 64'(ready_o), 64'd1);
    chk("abort_no_oe", 64'(outputEnable_o), 64'd0);
    @(negedge clk);
    reset_i = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_idle_ready", 64'(ready_o), 64'd1);
    issue(0, 2'd3, 0, 0, 64'h1C, 64'h0, 64'h0, 5'd9, 5'd0, 1);
    issue(0, 2'd3, 0, 0, 64'h10, 64'h0, 64'h0, 5'd9, 5'd0, 1);
    issue(0, 2'd3, 0, 0, 64'h20, 64'h0, 64'h0, 5'd9, 5'd0, 1);

    for (int i = 0; i < 50; i++) begin
      ea = 64'($urandom_range(0, MEMB - 1));
      issue(1'($urandom), 2'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
            64'h0, ea, {$urandom, $urandom},
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1);
    end
    drain();
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
